// File: rtl/rs_alu.sv
// rs_alu: reservation station feeding the integer ALU.
// Holds dispatched instructions and captures pending operands from the ALU and
// LSB result broadcasts. Each cycle it issues one fully ready entry, registered.
module rs_alu #(
  parameter int unsigned       ENTRIES  = 8,
  parameter int unsigned       IDX_W    = 3,
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       TAG_W    = 4,
  parameter int unsigned       NAME_W   = 5,
  parameter int unsigned       OP_W     = 6,
  parameter logic [TAG_W-1:0]  TAG_FREE = '1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clearEn,
  input  logic              dispEn,
  input  logic [DATA_W-1:0] dispDataO,
  input  logic [TAG_W-1:0]  dispTagO,
  input  logic [DATA_W-1:0] dispDataT,
  input  logic [TAG_W-1:0]  dispTagT,
  input  logic [TAG_W-1:0]  dispWrtTag,
  input  logic [NAME_W-1:0] dispWrtName,
  input  logic [OP_W-1:0]   dispOp,
  output logic              rsFull,
  input  logic              aluBcEn,
  input  logic [TAG_W-1:0]  aluBcTag,
  input  logic [DATA_W-1:0] aluBcData,
  input  logic              lsbBcEn,
  input  logic [TAG_W-1:0]  lsbBcTag,
  input  logic [DATA_W-1:0] lsbBcData,
  output logic              ALUworkEn,
  output logic [DATA_W-1:0] operandO,
  output logic [DATA_W-1:0] operandT,
  output logic [TAG_W-1:0]  wrtTag,
  output logic [NAME_W-1:0] wrtName,
  output logic [OP_W-1:0]   opCode
);

  logic [ENTRIES-1:0] valid;
  logic [OP_W-1:0]    e_op   [ENTRIES];
  logic [NAME_W-1:0]  e_name [ENTRIES];
  logic [TAG_W-1:0]   e_dest [ENTRIES];
  logic [DATA_W-1:0]  e_dato [ENTRIES];
  logic [TAG_W-1:0]   e_tago [ENTRIES];
  logic [DATA_W-1:0]  e_datt [ENTRIES];
  logic [TAG_W-1:0]   e_tagt [ENTRIES];

  logic               sel_found;
  logic [IDX_W-1:0]   sel_idx;
  logic [IDX_W-1:0]   free_idx;

  // Resolve one operand against both broadcast buses; ALU bus has priority.
  // A free tag never matches, so resolved operands are never overwritten.
  function automatic logic [TAG_W+DATA_W-1:0] wake(input logic [TAG_W-1:0]  tag,
                                                   input logic [DATA_W-1:0] data);
    if (tag != TAG_FREE && aluBcEn && aluBcTag == tag)
      return {TAG_FREE, aluBcData};
    else if (tag != TAG_FREE && lsbBcEn && lsbBcTag == tag)
      return {TAG_FREE, lsbBcData};
    else
      return {tag, data};
  endfunction

  // Full when every slot is occupied; a same-cycle issue does not free a slot early.
  assign rsFull = &valid;

  // Pick the lowest ready slot for issue and the lowest empty slot for dispatch.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    free_idx  = '0;
    for (int unsigned i = ENTRIES; i > 0; i--) begin
      if (valid[i-1] && e_tago[i-1] == TAG_FREE && e_tagt[i-1] == TAG_FREE) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i-1);
      end
      if (!valid[i-1])
        free_idx = IDX_W'(i-1);
    end
  end

  // Entry wakeup, issue register and dispatch write all update on the same edge.
  // The issued slot is valid, so it can never be the dispatch target this cycle.
  always_ff @(posedge clk) begin
    if (rst || clearEn) begin
      valid     <= '0;
      ALUworkEn <= 1'b0;
      operandO  <= '0;
      operandT  <= '0;
      wrtTag    <= TAG_FREE;
      wrtName   <= '0;
      opCode    <= '0;
    end else begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        if (valid[i]) begin
          {e_tago[i], e_dato[i]} <= wake(e_tago[i], e_dato[i]);
          {e_tagt[i], e_datt[i]} <= wake(e_tagt[i], e_datt[i]);
        end
      end

      if (sel_found) begin
        valid[sel_idx] <= 1'b0;
        ALUworkEn      <= 1'b1;
        operandO       <= e_dato[sel_idx];
        operandT       <= e_datt[sel_idx];
        wrtTag         <= e_dest[sel_idx];
        wrtName        <= e_name[sel_idx];
        opCode         <= e_op[sel_idx];
      end else begin
        ALUworkEn <= 1'b0;
        operandO  <= '0;
        operandT  <= '0;
        wrtTag    <= TAG_FREE;
        wrtName   <= '0;
        opCode    <= '0;
      end

      if (dispEn && !rsFull) begin
        valid[free_idx]                    <= 1'b1;
        e_op[free_idx]                     <= dispOp;
        e_name[free_idx]                   <= dispWrtName;
        e_dest[free_idx]                   <= dispWrtTag;
        {e_tago[free_idx], e_dato[free_idx]} <= wake(dispTagO, dispDataO);
        {e_tagt[free_idx], e_datt[free_idx]} <= wake(dispTagT, dispDataT);
      end
    end
  end

endmodule

// File: tb/tb_rs_alu.sv
// Directed bench for rs_alu: per-cycle vector table plus hand-written sequences
// for full/drop, multi-entry issue order and flush.
module tb_rs_alu;

  localparam logic [31:0] F = 32'hF;

  logic        clk = 1'b0;
  logic        rst, clearEn, dispEn, aluBcEn, lsbBcEn;
  logic [31:0] dispDataO, dispDataT, aluBcData, lsbBcData;
  logic [3:0]  dispTagO, dispTagT, dispWrtTag, aluBcTag, lsbBcTag;
  logic [4:0]  dispWrtName;
  logic [5:0]  dispOp;
  logic        rsFull, ALUworkEn;
  logic [31:0] operandO, operandT;
  logic [3:0]  wrtTag;
  logic [4:0]  wrtName;
  logic [5:0]  opCode;

  int errors = 0;
  int checks = 0;

  rs_alu #(.ENTRIES(8), .IDX_W(3), .DATA_W(32), .TAG_W(4), .NAME_W(5), .OP_W(6)) dut (
    .clk(clk), .rst(rst), .clearEn(clearEn), .dispEn(dispEn),
    .dispDataO(dispDataO), .dispTagO(dispTagO), .dispDataT(dispDataT), .dispTagT(dispTagT),
    .dispWrtTag(dispWrtTag), .dispWrtName(dispWrtName), .dispOp(dispOp), .rsFull(rsFull),
    .aluBcEn(aluBcEn), .aluBcTag(aluBcTag), .aluBcData(aluBcData),
    .lsbBcEn(lsbBcEn), .lsbBcTag(lsbBcTag), .lsbBcData(lsbBcData),
    .ALUworkEn(ALUworkEn), .operandO(operandO), .operandT(operandT),
    .wrtTag(wrtTag), .wrtName(wrtName), .opCode(opCode)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] de, dO, tO, dT, tT, wt, wn, op;
    logic [31:0] ab, at, ad, lb, lt, ld;
    logic [31:0] en, eO, eT, etag, ename, eop;
  } vec_t;

  vec_t vt [25];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; clearEn = 1'b0; dispEn = 1'b0; aluBcEn = 1'b0; lsbBcEn = 1'b0;
    dispDataO = '0; dispTagO = '1; dispDataT = '0; dispTagT = '1;
    dispWrtTag = '0; dispWrtName = '0; dispOp = '0;
    aluBcTag = '1; aluBcData = '0; lsbBcTag = '1; lsbBcData = '0;
  endtask

  task automatic disp(input logic [31:0] dO, input logic [3:0] tO, input logic [31:0] dT,
                      input logic [3:0] tT, input logic [3:0] wt, input logic [4:0] wn,
                      input logic [5:0] op);
    dispEn = 1'b1; dispDataO = dO; dispTagO = tO; dispDataT = dT; dispTagT = tT;
    dispWrtTag = wt; dispWrtName = wn; dispOp = op;
  endtask

  function automatic logic [79:0] outs();
    return {ALUworkEn, operandO, operandT, wrtTag, wrtName, opCode};
  endfunction

  function automatic logic [79:0] expo(input logic en, input logic [31:0] o, input logic [31:0] t,
                                       input logic [3:0] tg, input logic [4:0] nm, input logic [5:0] op);
    return {en, o, t, tg, nm, op};
  endfunction

  task automatic chk(input string nm, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  initial begin
    //        de dO     tO   dT     tT wt   wn op  ab at   ad      lb lt  ld      en eO      eT     etag ename eop
    vt[0]  = '{1, 5,     F,   7,     F, 2,   3, 1,  0, F,   0,      0, F,  0,      0, 0,      0,     F,   0,    0};
    vt[1]  = '{0, 0,     F,   0,     F, 0,   0, 0,  0, F,   0,      0, F,  0,      1, 5,      7,     2,   3,    1};
    vt[2]  = '{0, 0,     F,   0,     F, 0,   0, 0,  0, F,   0,      0, F,  0,      0, 0,      0,     F,   0,    0};
    vt[3]  = '{1, 0,     4,   8,     F, 5,   6, 2,  0, F,   0,      0, F,  0,      0, 0,      0,     F,   0,    0};
    vt[4]  = '{0, 0,     F,   0,     F, 0,   0, 0,  0, F,   0,      0, F,  0,      0, 0,      0,     F,   0,    0};
    vt[5]  = '{0, 0,     F,   0,     F, 0,   0, 0,  0, F,   0,      0, F,  0,      0, 0,      0,     F,   0,    0};
    vt[6]  = '{0, 0,     F,   0,     F, 0,   0, 0,  1, 4,   'h1234, 0, F,  0,      0, 0,      0,     F,   0,    0};
    vt[7]  = '{0, 0,     F,   0,     F, 0,   0, 0,  0, F,   0,      0, F,  0,      1, 'h1234, 8,     5,   6,    2};
    vt[8]  = '{0, 0,     F,   0,     F, 0,   0, 0,  0, F,   0,      0, F,  0,      0, 0,      0,     F,   0,    0};
    vt[9]  = '{1, 0,     3,   'h10,  F, 7,   8, 3,  0, F,   0,      0, F,  0,      0, 0,      0,     F,   0,    0};
    vt[10] = '{0, 0,     F,   0,     F, 0,   0, 0,  0, F,   0,      0, F,  0,      0, 0,      0,     F,   0,    0};
    vt[11] = '{0, 0,     F,   0,     F, 0,   0, 0,  0, F,   0,      0, F,  0,      0, 0,      0,     F,   0,    0};
    vt[12] = '{0, 0,     F,   0,     F, 0,   0, 0,  0, F,   0,      1, 3,  'hABCD, 0, 0,      0,     F,   0,    0};
    vt[13] = '{0, 0,     F,   0,     F, 0,   0, 0,  0, F,   0,      0, F,  0,      1, 'hABCD, 'h10,  7,   8,    3};
    vt[14] = '{0, 0,     F,   0,     F, 0,   0, 0,  0, F,   0,      0, F,  0,      0, 0,      0,     F,   0,    0};
    vt[15] = '{1, 2,     F,   0,     6, 1,   9, 4,  0, F,   0,      1, 6,  9,      0, 0,      0,     F,   0,    0};
    vt[16] = '{0, 0,     F,   0,     F, 0,   0, 0,  0, F,   0,      0, F,  0,      1, 2,      9,     1,   9,    4};
    vt[17] = '{0, 0,     F,   0,     F, 0,   0, 0,  0, F,   0,      0, F,  0,      0, 0,      0,     F,   0,    0};
    vt[18] = '{1, 0,     'hA, 1,     F, 3,   1, 5,  0, F,   0,      0, F,  0,      0, 0,      0,     F,   0,    0};
    vt[19] = '{0, 0,     F,   0,     F, 0,   0, 0,  1, 'hA, 'h11,   1, 'hA, 'h22,  0, 0,      0,     F,   0,    0};
    vt[20] = '{0, 0,     F,   0,     F, 0,   0, 0,  0, F,   0,      0, F,  0,      1, 'h11,   1,     3,   1,    5};
    vt[21] = '{0, 0,     F,   0,     F, 0,   0, 0,  0, F,   0,      0, F,  0,      0, 0,      0,     F,   0,    0};
    vt[22] = '{1, 'h55,  F,   'h66,  F, 4,   2, 6,  1, F,   'h99,   1, F,  'hAA,   0, 0,      0,     F,   0,    0};
    vt[23] = '{0, 0,     F,   0,     F, 0,   0, 0,  0, F,   0,      0, F,  0,      1, 'h55,   'h66,  4,   2,    6};
    vt[24] = '{0, 0,     F,   0,     F, 0,   0, 0,  0, F,   0,      0, F,  0,      0, 0,      0,     F,   0,    0};

    // Reset state
    idle();
    rst = 1'b1;
    tick();
    chk("reset_outputs", outs(), expo(0, 0, 0, 4'hF, 0, 0));
    chk("reset_full", 80'(rsFull), 80'(0));
    idle();

    // Per-cycle vectors: drive, clock, compare registered outputs
    for (int i = 0; i < 25; i++) begin
      dispEn = vt[i].de[0]; dispDataO = vt[i].dO; dispTagO = vt[i].tO[3:0];
      dispDataT = vt[i].dT; dispTagT = vt[i].tT[3:0]; dispWrtTag = vt[i].wt[3:0];
      dispWrtName = vt[i].wn[4:0]; dispOp = vt[i].op[5:0];
      aluBcEn = vt[i].ab[0]; aluBcTag = vt[i].at[3:0]; aluBcData = vt[i].ad;
      lsbBcEn = vt[i].lb[0]; lsbBcTag = vt[i].lt[3:0]; lsbBcData = vt[i].ld;
      tick();
      chk($sformatf("vec%0d", i), outs(),
          expo(vt[i].en[0], vt[i].eO, vt[i].eT, vt[i].etag[3:0], vt[i].ename[4:0], vt[i].eop[5:0]));
    end
    idle();

    // Fill all slots with dependent entries, drop a ninth, then free slot 0
    clearEn = 1'b1; tick(); idle();
    for (int i = 0; i < 8; i++) begin
      disp(0, 4'(i), 32'(100 + i), 4'hF, 4'(i), 5'(i), 6'(i));
      tick();
    end
    idle();
    chk("fill_full", 80'(rsFull), 80'(1));
    chk("fill_no_issue", outs(), expo(0, 0, 0, 4'hF, 0, 0));
    disp('h33, 4'hF, 'h44, 4'hF, 9, 9, 9);
    tick(); idle();
    chk("drop_full", 80'(rsFull), 80'(1));
    tick();
    chk("drop_no_issue", outs(), expo(0, 0, 0, 4'hF, 0, 0));
    aluBcEn = 1'b1; aluBcTag = 4'h0; aluBcData = 'h77;
    tick(); idle();
    chk("wake0_full", 80'(rsFull), 80'(1));
    chk("wake0_no_issue_yet", outs(), expo(0, 0, 0, 4'hF, 0, 0));
    tick();
    chk("wake0_issue", outs(), expo(1, 'h77, 100, 0, 0, 0));
    chk("wake0_not_full", 80'(rsFull), 80'(0));
    disp(1, 4'hF, 2, 4'hF, 4'hC, 5'hC, 6'hC);
    tick(); idle();
    chk("refill_full", 80'(rsFull), 80'(1));
    tick();
    chk("refill_issue", outs(), expo(1, 1, 2, 4'hC, 5'hC, 6'hC));
    chk("refill_not_full", 80'(rsFull), 80'(0));

    // Slots 1, 4, 6 woken together issue in index order
    clearEn = 1'b1; tick(); idle();
    for (int i = 0; i < 7; i++) begin
      disp(32'(i * 16), (i == 1 || i == 4 || i == 6) ? 4'h9 : 4'hE, 32'('h50 + i), 4'hF,
           4'(i), 5'(i), 6'h1);
      tick();
    end
    idle();
    aluBcEn = 1'b1; aluBcTag = 4'h9; aluBcData = 'h900;
    tick(); idle();
    chk("order_wait", outs(), expo(0, 0, 0, 4'hF, 0, 0));
    tick();
    chk("order_slot1", outs(), expo(1, 'h900, 'h51, 1, 1, 1));
    tick();
    chk("order_slot4", outs(), expo(1, 'h900, 'h54, 4, 4, 1));
    tick();
    chk("order_slot6", outs(), expo(1, 'h900, 'h56, 6, 6, 1));
    tick();
    chk("order_done", outs(), expo(0, 0, 0, 4'hF, 0, 0));

    // Flush with five valid entries (last one ready), dispatch and wakeup in the same cycle
    clearEn = 1'b1; tick(); idle();
    for (int i = 0; i < 5; i++) begin
      disp(0, (i == 4) ? 4'hF : 4'h8, 3, 4'hF, 4'(i), 5'(i), 6'h2);
      tick();
    end
    idle();
    clearEn = 1'b1;
    disp(7, 4'hF, 8, 4'hF, 4'hB, 5'hB, 6'hB);
    aluBcEn = 1'b1; aluBcTag = 4'h8; aluBcData = 'hDEAD;
    tick(); idle();
    chk("flush_not_full", 80'(rsFull), 80'(0));
    chk("flush_no_issue", outs(), expo(0, 0, 0, 4'hF, 0, 0));
    aluBcEn = 1'b1; aluBcTag = 4'h8; aluBcData = 'hBEEF;
    for (int i = 0; i < 4; i++) begin
      tick(); idle();
      chk($sformatf("flush_quiet%0d", i), outs(), expo(0, 0, 0, 4'hF, 0, 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
